// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman draw sequencer: stage geometry,
// counter widths and the state encodings of the frame FSM and copy handshake.
package bomberman_pkg;

  localparam int STAGE_DIM = 11;
  localparam int NUM_TILES = STAGE_DIM * STAGE_DIM;
  localparam int TILE_W    = 7;
  localparam int OVR_W     = 8;

  typedef enum logic [2:0] {
    ST_INIT_TILES   = 3'd0,
    ST_WAIT_FRAME   = 3'd1,
    ST_ERASE_P1     = 3'd2,
    ST_ERASE_P2     = 3'd3,
    ST_MOVE         = 3'd4,
    ST_DRAW_P1      = 3'd5,
    ST_DRAW_P2      = 3'd6,
    ST_REDRAW_TILES = 3'd7
  } state_t;

  // ISSUE: selects low, go fires next cycle. GO: one-cycle go. WAIT: hold for finish.
  typedef enum logic [1:0] {
    HS_ISSUE = 2'd0,
    HS_GO    = 2'd1,
    HS_WAIT  = 2'd2
  } hs_phase_t;

endpackage

// File: rtl/draw_handshake.sv
// One go/finished exchange with the copy unit: go pulses the cycle after the
// owner becomes active, then the selects are held until copy_finished is seen.
module draw_handshake
  import bomberman_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic copy_finished,
  output logic go,
  output logic hold,
  output logic done
);

  hs_phase_t phase, phase_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) phase <= HS_ISSUE;
    else       phase <= phase_next;
  end

  // A finish is honoured only in WAIT, so stray pulses elsewhere are dropped.
  always_comb begin
    phase_next = phase;
    go         = 1'b0;
    hold       = 1'b0;
    done       = 1'b0;
    case (phase)
      HS_ISSUE: if (active) phase_next = HS_GO;
      HS_GO: begin
        go         = 1'b1;
        hold       = 1'b1;
        phase_next = HS_WAIT;
      end
      HS_WAIT: begin
        hold = 1'b1;
        if (copy_finished) begin
          done       = 1'b1;
          phase_next = HS_ISSUE;
        end
      end
      default: phase_next = HS_ISSUE;
    endcase
  end

endmodule

// File: rtl/bomberman_draw_sequencer.sv
// Frame-level draw controller: paints the stage after reset, then erases, moves
// and redraws both players every frame. BOMBERMAN_FULL_REDRAW_EN swaps the erases for a full tile redraw.
module bomberman_draw_sequencer
  import bomberman_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              copy_finished,
  output logic              copy_go,
  output logic              draw_t,
  output logic              draw_p1,
  output logic              draw_p2,
  output logic              erase,
  output logic [TILE_W-1:0] tile_index,
  output logic              p1_move_en,
  output logic              p2_move_en,
  output logic              busy,
  output logic [OVR_W-1:0]  frame_overruns
);

`ifdef BOMBERMAN_FULL_REDRAW_EN
  localparam state_t FRAME_FIRST = ST_REDRAW_TILES;
`else
  localparam state_t FRAME_FIRST = ST_ERASE_P1;
`endif

  state_t state, state_next;
  logic   tile_state, hs_active, hs_go, hs_hold, hs_done;
  logic   last_tile, tick_taken, pending;

  assign tile_state = (state == ST_INIT_TILES) || (state == ST_REDRAW_TILES);
  assign hs_active  = tile_state || (state == ST_ERASE_P1) || (state == ST_ERASE_P2) ||
                      (state == ST_DRAW_P1) || (state == ST_DRAW_P2);
  assign last_tile  = (tile_index == TILE_W'(NUM_TILES - 1));
  assign tick_taken = (state == ST_WAIT_FRAME) && (frame_tick || pending);

  draw_handshake u_handshake (
    .clock         (clock),
    .reset         (reset),
    .active        (hs_active),
    .copy_finished (copy_finished),
    .go            (hs_go),
    .hold          (hs_hold),
    .done          (hs_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_INIT_TILES;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    copy_go    = hs_go;
    draw_t     = 1'b0;
    draw_p1    = 1'b0;
    draw_p2    = 1'b0;
    erase      = 1'b0;
    p1_move_en = 1'b0;
    p2_move_en = 1'b0;
    case (state)
      ST_INIT_TILES: begin
        draw_t = hs_hold;
        if (hs_done && last_tile) state_next = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: if (tick_taken) state_next = FRAME_FIRST;
      ST_ERASE_P1: begin
        draw_p1 = hs_hold;
`ifndef BOMBERMAN_FULL_REDRAW_EN
        erase   = hs_hold;
`endif
        if (hs_done) state_next = ST_ERASE_P2;
      end
      ST_ERASE_P2: begin
        draw_p2 = hs_hold;
`ifndef BOMBERMAN_FULL_REDRAW_EN
        erase   = hs_hold;
`endif
        if (hs_done) state_next = ST_MOVE;
      end
      ST_MOVE: begin
        p1_move_en = 1'b1;
        p2_move_en = 1'b1;
        state_next = ST_DRAW_P1;
      end
      ST_DRAW_P1: begin
        draw_p1 = hs_hold;
        if (hs_done) state_next = ST_DRAW_P2;
      end
      ST_DRAW_P2: begin
        draw_p2 = hs_hold;
        if (hs_done) state_next = ST_WAIT_FRAME;
      end
      ST_REDRAW_TILES: begin
        draw_t = hs_hold;
        if (hs_done && last_tile) state_next = ST_MOVE;
      end
      default: state_next = ST_INIT_TILES;
    endcase
  end

  // busy is registered so it reads 0 while reset is applied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy           <= 1'b0;
      tile_index     <= '0;
      pending        <= 1'b0;
      frame_overruns <= '0;
    end else begin
      busy <= (state_next != ST_WAIT_FRAME);
      if (tile_state && hs_done) tile_index <= last_tile ? '0 : tile_index + 1'b1;
      if (tick_taken) begin
        pending <= 1'b0;
      end else if (frame_tick && (state != ST_WAIT_FRAME)) begin
        if (!pending)                  pending        <= 1'b1;
        else if (frame_overruns != '1) frame_overruns <= frame_overruns + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bomberman_draw_sequencer.sv
// Self-checking bench for bomberman_draw_sequencer: a copy-unit responder, a
// job-level scoreboard of expected go/move events, and one task per scenario.
module tb_bomberman_draw_sequencer;
  import bomberman_pkg::*;

  localparam int EW = TILE_W + 5;
`ifdef BOMBERMAN_FULL_REDRAW_EN
  localparam int FRAME_GOS = NUM_TILES + 2;
`else
  localparam int FRAME_GOS = 4;
`endif
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              copy_finished = 1'b0;
  logic              copy_go, draw_t, draw_p1, draw_p2, erase;
  logic [TILE_W-1:0] tile_index;
  logic              p1_move_en, p2_move_en, busy;
  logic [OVR_W-1:0]  frame_overruns;

  int n_checks = 0;
  int n_fails  = 0;
  logic [EW-1:0] exp_q[$];
  bit auto_fin = 1, rand_delay = 0, spur_req = 0, spur_on_move = 0, suppress_57 = 0;
  int cnt = 0, go_count = 0, move_count = 0, exp_ovr = 0;
  bit fin_now;
  logic [EW-1:0] obs, expw;

  bomberman_draw_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .copy_finished  (copy_finished),
    .copy_go        (copy_go),
    .draw_t         (draw_t),
    .draw_p1        (draw_p1),
    .draw_p2        (draw_p2),
    .erase          (erase),
    .tile_index     (tile_index),
    .p1_move_en     (p1_move_en),
    .p2_move_en     (p2_move_en),
    .busy           (busy),
    .frame_overruns (frame_overruns)
  );

  // clock / reset block
  initial forever #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // expected job word: {move, tile, p1, p2, erase, tile_index}
  function automatic logic [EW-1:0] job(bit mv, bit t, bit p1, bit p2, bit er, int idx);
    job = {mv, t, p1, p2, er, TILE_W'(idx)};
  endfunction

  function automatic int sat_add(int a, int b);
    sat_add = (a + b > OVR_MAX) ? OVR_MAX : a + b;
  endfunction

  task automatic push_tiles();
    for (int i = 0; i < NUM_TILES; i++) exp_q.push_back(job(0, 1, 0, 0, 0, i));
  endtask

  task automatic push_frame();
`ifdef BOMBERMAN_FULL_REDRAW_EN
    push_tiles();
`else
    exp_q.push_back(job(0, 0, 1, 0, 1, 0));
    exp_q.push_back(job(0, 0, 0, 1, 1, 0));
`endif
    exp_q.push_back(job(1, 0, 0, 0, 0, 0));
    exp_q.push_back(job(0, 0, 1, 0, 0, 0));
    exp_q.push_back(job(0, 0, 0, 1, 0, 0));
  endtask

  // copy-unit responder: finishes each go after a fixed or random delay
  initial forever begin
    @(negedge clock);
    fin_now = 1'b0;
    if (reset) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) fin_now = 1'b1;
      end
      if (copy_go && auto_fin && !(suppress_57 && tile_index == 7'd57))
        cnt = rand_delay ? int'($urandom_range(1, 5)) : 3;
    end
    copy_finished = fin_now | spur_req | (spur_on_move & p1_move_en);
  end

  // scoreboard: every go or move pulse must match the next expected job
  initial forever begin
    @(negedge clock);
    if (!reset && (copy_go || p1_move_en || p2_move_en)) begin
      obs = {p1_move_en & p2_move_en, draw_t, draw_p1, draw_p2, erase, tile_index};
      if (copy_go) go_count++;
      if (p1_move_en) move_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL job_unexpected: got %h go=%b move=%b%b, required no event", obs, copy_go,
                 p1_move_en, p2_move_en);
      end else begin
        expw = exp_q.pop_front();
        if (copy_go && (p1_move_en || p2_move_en)) obs = ~expw;
        if (obs !== expw) begin
          n_fails++;
          $display("FAIL job_seq: got %h, required %h", obs, expw);
        end
      end
    end
  end

  task automatic pulse_tick();
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
  endtask

  task automatic hold_ticks(input int n);
    repeat (n) begin
      @(negedge clock); frame_tick = 1'b1;
    end
    @(negedge clock); frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({copy_go, draw_t, draw_p1, draw_p2, erase, tile_index, p1_move_en, p2_move_en, busy,
         frame_overruns} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: go=%b t=%b p1=%b p2=%b er=%b idx=%0d busy=%b ovr=%0d, required all 0",
               copy_go, draw_t, draw_p1, draw_p2, erase, tile_index, busy, frame_overruns);
    end
    push_tiles();
    go_count = 0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (copy_go !== 1'b0) begin
      n_fails++;
      $display("FAIL first_issue: go=%b, required 0", copy_go);
    end
    @(negedge clock);
    n_checks++;
    if (copy_go !== 1'b1 || draw_t !== 1'b1) begin
      n_fails++;
      $display("FAIL first_go: go=%b t=%b, required 1 1", copy_go, draw_t);
    end
  endtask

  task automatic test_init_tiles();
    bit ok;
    wait_idle(4000, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL init_done: queue=%0d busy=%b, required empty and idle", exp_q.size(), busy);
    end
    n_checks++;
    if (go_count !== NUM_TILES || tile_index !== '0) begin
      n_fails++;
      $display("FAIL init_count: gos=%0d idx=%0d, required %0d 0", go_count, tile_index, NUM_TILES);
    end
  endtask

  task automatic test_frame();
    bit ok;
    rand_delay = 1;
    go_count = 0;
    move_count = 0;
    push_frame();
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    n_checks++;
    if (copy_go !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL tick_latency_pre: go=%b busy=%b, required 0 1", copy_go, busy);
    end
    @(negedge clock);
    n_checks++;
    if (copy_go !== 1'b1) begin
      n_fails++;
      $display("FAIL tick_latency_go: go=%b, required 1", copy_go);
    end
    wait_idle(4000, ok);
    n_checks++;
    if (!ok || go_count !== FRAME_GOS || move_count !== 1) begin
      n_fails++;
      $display("FAIL frame: idle=%b gos=%0d moves=%0d, required 1 %0d 1", ok, go_count, move_count,
               FRAME_GOS);
    end
    repeat (5) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || go_count !== FRAME_GOS) begin
      n_fails++;
      $display("FAIL frame_settle: busy=%b gos=%0d, required 0 %0d", busy, go_count, FRAME_GOS);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    go_count = 0;
    move_count = 0;
    @(posedge clock); #1 spur_req = 1'b1;
    @(posedge clock); #1 spur_req = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || go_count !== 0) begin
      n_fails++;
      $display("FAIL spurious_wait: busy=%b gos=%0d, required 0 0", busy, go_count);
    end
    @(posedge clock); #1 spur_on_move = 1'b1;
    push_frame();
    pulse_tick();
    wait_idle(4000, ok);
    n_checks++;
    if (!ok || go_count !== FRAME_GOS || move_count !== 1) begin
      n_fails++;
      $display("FAIL spurious_move: idle=%b gos=%0d moves=%0d, required 1 %0d 1", ok, go_count,
               move_count, FRAME_GOS);
    end
    @(posedge clock); #1 spur_on_move = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    go_count = 0;
    move_count = 0;
    push_frame();
    push_frame();
    pulse_tick();
    repeat ($urandom_range(1, 3)) @(negedge clock);
    pulse_tick();
    repeat ($urandom_range(1, 3)) @(negedge clock);
    pulse_tick();
    exp_ovr = sat_add(exp_ovr, 1);
    wait_idle(8000, ok);
    n_checks++;
    if (!ok || go_count !== 2 * FRAME_GOS || move_count !== 2) begin
      n_fails++;
      $display("FAIL back_to_back: idle=%b gos=%0d moves=%0d, required 1 %0d 2", ok, go_count,
               move_count, 2 * FRAME_GOS);
    end
    n_checks++;
    if (frame_overruns !== OVR_W'(exp_ovr)) begin
      n_fails++;
      $display("FAIL overrun_one: got %0d, required %0d", frame_overruns, exp_ovr);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    @(posedge clock); #1 auto_fin = 1'b0;
    go_count = 0;
    push_frame();
    push_frame();
    pulse_tick();
    hold_ticks(101);
    exp_ovr = sat_add(exp_ovr, 100);
    n_checks++;
    if (frame_overruns !== OVR_W'(exp_ovr) || busy !== 1'b1 || go_count !== 1) begin
      n_fails++;
      $display("FAIL overrun_mid: ovr=%0d busy=%b gos=%0d, required %0d 1 1", frame_overruns, busy,
               go_count, exp_ovr);
    end
    hold_ticks(200);
    exp_ovr = sat_add(exp_ovr, 200);
    n_checks++;
    if (frame_overruns !== OVR_W'(exp_ovr)) begin
      n_fails++;
      $display("FAIL overrun_sat: got %0d, required %0d", frame_overruns, exp_ovr);
    end
    @(posedge clock); #1 auto_fin = 1'b1; spur_req = 1'b1;
    @(posedge clock); #1 spur_req = 1'b0;
    wait_idle(8000, ok);
    n_checks++;
    if (!ok || frame_overruns !== OVR_W'(exp_ovr)) begin
      n_fails++;
      $display("FAIL overrun_drain: idle=%b ovr=%0d, required 1 %0d", ok, frame_overruns, exp_ovr);
    end
  endtask

  task automatic test_reset_mid_init();
    bit ok, found;
    @(posedge clock); #1 suppress_57 = 1'b1;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({copy_go, draw_t, busy, frame_overruns} !== '0) begin
      n_fails++;
      $display("FAIL reset_clears_ovr: go=%b t=%b busy=%b ovr=%0d, required all 0", copy_go,
               draw_t, busy, frame_overruns);
    end
    push_tiles();
    @(posedge clock); #1 reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (copy_go === 1'b1 && tile_index === 7'd57) begin
        found = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (!found || draw_t !== 1'b1 || copy_go !== 1'b0 || tile_index !== 7'd57) begin
      n_fails++;
      $display("FAIL awaiting_57: found=%b t=%b go=%b idx=%0d, required 1 1 0 57", found, draw_t,
               copy_go, tile_index);
    end
    @(posedge clock); #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({copy_go, draw_t, draw_p1, draw_p2, erase, tile_index, p1_move_en, p2_move_en, busy,
         frame_overruns} !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_outputs: go=%b t=%b idx=%0d busy=%b, required all 0", copy_go,
               draw_t, tile_index, busy);
    end
    exp_q.delete();
    suppress_57 = 1'b0;
    push_tiles();
    go_count = 0;
    exp_ovr = 0;
    @(posedge clock); #1 reset = 1'b0;
    wait_idle(6000, ok);
    n_checks++;
    if (!ok || go_count !== NUM_TILES || tile_index !== '0 || frame_overruns !== '0) begin
      n_fails++;
      $display("FAIL reinit: idle=%b gos=%0d idx=%0d ovr=%0d, required 1 %0d 0 0", ok, go_count,
               tile_index, frame_overruns, NUM_TILES);
    end
  endtask

  initial begin
    test_reset();
    test_init_tiles();
    test_frame();
    test_spurious();
    test_back_to_back();
    test_saturation();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
